// File: rtl/arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arb_pkg : shared arbiter/grant-mux FSM states and index helper      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // A single port still needs a one-bit index to keep vectors legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_to_index.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | onehot_to_index : grant vector -> binary index, one-hot/zero flags  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module onehot_to_index
  import arb_pkg::*;
#(
  parameter  int PORTS = 2,
  localparam int IDX_W = idx_width(PORTS)
) (
  input  logic [PORTS-1:0] i_vec,
  output logic [IDX_W-1:0] o_index,
  output logic             o_onehot,
  output logic             o_zero
);

  // OR-reduction of set-bit positions; exact whenever the vector is one-hot.
  always_comb begin
    o_index = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (i_vec[k]) o_index = o_index | IDX_W'(k);
    end
  end

  assign o_zero   = (i_vec == '0);
  assign o_onehot = !o_zero && ((i_vec & (i_vec - PORTS'(1))) == '0);

endmodule
`default_nettype wire

// File: rtl/grant_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | grant_mux : packet mux locked to an arbiter grant, 1-deep out reg   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module grant_mux
  import arb_pkg::*;
#(
  parameter int PORTS  = 2,
  parameter int DATA_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [PORTS-1:0]         i_grant,
  input  logic [PORTS-1:0]         i_valid,
  input  logic [PORTS*DATA_W-1:0]  i_data,
  input  logic [PORTS-1:0]         i_last,
  output logic [PORTS-1:0]         o_ready,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_last,
  input  logic                     i_ready,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err
);

  localparam int IDX_W = idx_width(PORTS);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [IDX_W-1:0]    grant_idx;
  logic                grant_onehot;
  logic                grant_zero;
  logic                ready_sel;
  logic                in_hs;
  logic                out_hs;

  onehot_to_index #(.PORTS(PORTS)) u_idx (
    .i_vec    (i_grant),
    .o_index  (grant_idx),
    .o_onehot (grant_onehot),
    .o_zero   (grant_zero)
  );

  assign ready_sel = !valid_q || i_ready;
  assign in_hs     = (state_q == S_XFER) && i_valid[sel_q] && ready_sel;
  assign out_hs    = valid_q && i_ready;

  always_comb begin
    o_ready = '0;
    if (state_q == S_XFER) o_ready[sel_q] = ready_sel;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = err_q;

    // A load takes priority over a drain so back-to-back beats leave no bubble.
    if (in_hs) begin
      valid_d = 1'b1;
      data_d  = i_data[int'(sel_q)*DATA_W +: DATA_W];
      last_d  = i_last[sel_q];
    end else if (out_hs) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (grant_onehot) begin
          sel_d   = grant_idx;
          state_d = S_XFER;
        end else if (!grant_zero) begin
          err_d = 1'b1;
        end
      end
      S_XFER: begin
        if (in_hs && i_last[sel_q]) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_hs && last_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_grant_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_grant_mux : random + directed bench against a packet-level model |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_grant_mux;

  localparam int P  = 2;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [P-1:0]    grant, valid, last, o_ready;
  logic [P*DW-1:0] data;
  logic            ready_in;
  logic            o_valid, o_last, o_busy, o_done, o_err;
  logic [DW-1:0]   o_data;

  grant_mux #(.PORTS(P), .DATA_W(DW)) dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_grant (grant),
    .i_valid (valid),
    .i_data  (data),
    .i_last  (last),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last),
    .i_ready (ready_in),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packet-level reference: the port that owns the mux (-1 when free),
  // whether its last beat has been taken, and a FIFO of beats not yet sent.
  typedef struct packed { logic l; logic [DW-1:0] d; } beat_t;
  beat_t m_q[$];
  int    m_port;
  bit    m_last_taken, m_done, m_err;

  task automatic model_reset();
    m_port = -1; m_last_taken = 0; m_done = 0; m_err = 0;
    m_q.delete();
  endtask

  task automatic step(input logic [P-1:0] g, input logic [P-1:0] v,
                      input logic [P*DW-1:0] d, input logic [P-1:0] l, input logic r);
    logic [P-1:0] er;
    bit    in_hs, out_hs;
    int    p;
    beat_t b;
    @(negedge clk);
    grant = g; valid = v; data = d; last = l; ready_in = r;
    #1;
    er = '0;
    if (m_port >= 0 && !m_last_taken && (m_q.size() == 0 || r)) er[m_port] = 1'b1;
    chk("o_ready", 32'(o_ready), 32'(er));
    chk("o_valid", 32'(o_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("o_data", 32'(o_data), 32'(m_q[0].d));
      chk("o_last", 32'(o_last), 32'(m_q[0].l));
    end
    chk("o_busy", 32'(o_busy), 32'(m_port >= 0));
    chk("o_done", 32'(o_done), 32'(m_done));
    chk("o_err",  32'(o_err),  32'(m_err));

    p      = m_port;
    in_hs  = 0;
    if (p >= 0) in_hs = er[p] && v[p];
    out_hs = (m_q.size() > 0) && r;
    m_done = 0;
    if (p < 0) begin
      if ($countones(g) == 1) begin
        for (int k = 0; k < P; k++) if (g[k]) m_port = k;
      end else if (g != '0) begin
        m_err = 1;
      end
    end else begin
      if (out_hs) begin
        b = m_q.pop_front();
        if (b.l) begin m_port = -1; m_last_taken = 0; m_done = 1; end
      end
      if (in_hs) begin
        b.d = d[p*DW +: DW];
        b.l = l[p];
        m_q.push_back(b);
        if (b.l) m_last_taken = 1;
      end
    end
  endtask

  task automatic rand_step(input bit allow_bad);
    logic [P-1:0] g;
    logic [P-1:0] l;
    int s;
    s = $urandom_range(0, 19);
    if (s < 8)       g = 2'b01;
    else if (s < 16) g = 2'b10;
    else if (s < 19 || !allow_bad) g = 2'b00;
    else             g = 2'b11;
    l[0] = ($urandom_range(0, 3) == 0);
    l[1] = ($urandom_range(0, 3) == 0);
    step(g, P'($urandom), (P*DW)'($urandom), l, ($urandom_range(0, 3) != 0));
  endtask

  initial begin
    rstn = 1'b1; grant = '0; valid = '0; data = '0; last = '0; ready_in = 1'b0;
    model_reset();
    #1 rstn = 1'b0;
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data",  32'(o_data),  0);
    chk("rst_busy",  32'(o_busy),  0);
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_err",   32'(o_err),   0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;

    // Three-beat packet on port 0 while the grant and port 1 try to interfere.
    step(2'b01, 2'b00, 16'h0000, 2'b00, 1);
    step(2'b10, 2'b11, 16'hB1A1, 2'b00, 1);
    step(2'b10, 2'b11, 16'hB2A2, 2'b10, 1);
    step(2'b10, 2'b11, 16'hB3A3, 2'b01, 1);
    step(2'b10, 2'b10, 16'hB400, 2'b10, 1);
    // Grant 10 in the done cycle starts port 1; stall the output for 3 cycles.
    step(2'b10, 2'b10, 16'hC100, 2'b00, 1);
    step(2'b00, 2'b10, 16'hC100, 2'b00, 1);
    step(2'b00, 2'b10, 16'hC200, 2'b00, 0);
    step(2'b00, 2'b10, 16'hC200, 2'b00, 0);
    step(2'b00, 2'b10, 16'hC200, 2'b00, 0);
    step(2'b00, 2'b10, 16'hC200, 2'b10, 1);
    step(2'b00, 2'b00, 16'h0000, 2'b00, 1);
    step(2'b00, 2'b00, 16'h0000, 2'b00, 1);
    // Single-beat packet, then back-to-back grant in the done cycle.
    step(2'b01, 2'b00, 16'h0000, 2'b00, 1);
    step(2'b00, 2'b01, 16'h005A, 2'b01, 1);
    step(2'b00, 2'b00, 16'h0000, 2'b00, 1);
    step(2'b01, 2'b00, 16'h0000, 2'b00, 1);
    step(2'b00, 2'b01, 16'h0033, 2'b01, 1);
    step(2'b00, 2'b00, 16'h0000, 2'b00, 1);
    // Illegal grant: sticky error, no lock.
    step(2'b11, 2'b11, 16'hFFFF, 2'b11, 1);
    step(2'b00, 2'b00, 16'h0000, 2'b00, 1);

    for (int i = 0; i < 3000; i++) rand_step(1'b1);

    // Let any open packet finish, then park a last beat in the output register.
    for (int i = 0; i < 200 && m_port >= 0; i++)
      step(2'b00, 2'b11, (P*DW)'($urandom), 2'b11, 1);
    chk("drain_settle", 32'(m_port >= 0), 0);
    step(2'b01, 2'b00, 16'h0000, 2'b00, 0);
    step(2'b00, 2'b01, 16'h0077, 2'b01, 0);
    step(2'b00, 2'b00, 16'h0000, 2'b00, 0);
    grant = '0; valid = '0; last = '0;
    @(posedge clk); #2;
    chk("pre_rst_busy",  32'(o_busy),  1);
    chk("pre_rst_valid", 32'(o_valid), 1);
    rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 0);
    chk("arst_busy",  32'(o_busy),  0);
    chk("arst_ready", 32'(o_ready), 0);
    chk("arst_data",  32'(o_data),  0);
    chk("arst_last",  32'(o_last),  0);
    chk("arst_done",  32'(o_done),  0);
    chk("arst_err",   32'(o_err),   0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    step(2'b00, 2'b00, 16'h0000, 2'b00, 1);
    for (int i = 0; i < 500; i++) rand_step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
